// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and helpers for the ysyx_24100005 load/store unit.
// Holds the FSM state encoding, the funct3 codes and the access-size byte mask.
package ysyx_24100005_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Byte-enable pattern at lane 0; funct3[1:0] encodes log2 of the access size.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational byte-lane logic for the LSU: store shift, write mask,
// load extraction and sign/zero extension.
module ysyx_24100005_lsu_align
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]        st_funct3,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_data_sh,
    output logic [NB-1:0]     st_mask,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] ld_ext
);

    logic [DATA_W-1:0] ld_sh;

    always_comb begin
        st_data_sh = st_data << {st_off, 3'b000};
        st_mask    = NB'(size_mask(st_funct3)) << st_off;
    end

    always_comb begin
        ld_sh = ld_data >> {ld_off, 3'b000};
        // Size casts of a signed operand sign-extend; of an unsigned one, zero-extend.
        case (ld_funct3)
            F3_B:    ld_ext = DATA_W'($signed(ld_sh[7:0]));
            F3_H:    ld_ext = DATA_W'($signed(ld_sh[15:0]));
            F3_W:    ld_ext = DATA_W'($signed(ld_sh[31:0]));
            F3_BU:   ld_ext = DATA_W'(ld_sh[7:0]);
            F3_HU:   ld_ext = DATA_W'(ld_sh[15:0]);
            F3_WU:   ld_ext = DATA_W'(ld_sh[31:0]);
            default: ld_ext = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: request latch, bus FSM, timeout and response.
// Optional macro YSYX_24100005_LSU_MISALIGN_CHK_EN turns misaligned accesses into errors.
module ysyx_24100005_lsu
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int          NB      = DATA_W / 8;
    localparam int          OFF_W   = $clog2(NB);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       cnt;
    logic [2:0]        lat_funct3;
    logic [OFF_W-1:0]  lat_off;

    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  lo_mask;
    logic [OFF_W-1:0]  eff_off;
    logic              f3_legal;
    logic              req_bad;
    logic              timeout;
    logic [DATA_W-1:0] st_data_sh;
    logic [NB-1:0]     st_mask;
    logic [DATA_W-1:0] ld_ext;

    assign req_off = req_addr[OFF_W-1:0];
    assign lo_mask = OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1);

    always_comb begin
        f3_legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                F3_B, F3_H, F3_W: f3_legal = 1'b1;
                F3_D:             f3_legal = (DATA_W == 64);
                default:          f3_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
                F3_D, F3_WU:                    f3_legal = (DATA_W == 64);
                default:                        f3_legal = 1'b0;
            endcase
        end
    end

`ifdef YSYX_24100005_LSU_MISALIGN_CHK_EN
    assign eff_off = req_off;
    assign req_bad = !f3_legal || (|(req_off & lo_mask));
`else
    // Sub-size offset bits are dropped so the access lands on its natural boundary.
    assign eff_off = req_off & ~lo_mask;
    assign req_bad = !f3_legal;
`endif

    ysyx_24100005_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_funct3  (req_funct3),
        .st_off     (eff_off),
        .st_data    (req_wdata),
        .st_data_sh (st_data_sh),
        .st_mask    (st_mask),
        .ld_funct3  (lat_funct3),
        .ld_off     (lat_off),
        .ld_data    (mem_rdata),
        .ld_ext     (ld_ext)
    );

    assign timeout    = ((state == S_ADDR) || (state == S_WAIT)) && (cnt == TO_LAST);
    assign req_ready  = (state == S_IDLE);
    assign mem_valid  = (state == S_ADDR);
    assign resp_valid = (state == S_RESP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid) state_nxt = req_bad ? S_RESP : S_ADDR;
            S_ADDR: begin
                if (timeout)        state_nxt = S_RESP;
                else if (mem_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (timeout)         state_nxt = S_RESP;
                else if (mem_rvalid) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_funct3 <= '0;
            lat_off    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cnt <= '0;
                        if (req_bad) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            lat_funct3 <= req_funct3;
                            lat_off    <= eff_off;
                            mem_we     <= req_we;
                            mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata  <= st_data_sh;
                            mem_wmask  <= st_mask;
                        end
                    end
                end
                S_ADDR, S_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (timeout) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (state == S_WAIT && mem_rvalid) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= mem_we ? '0 : ld_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed self-checking bench for ysyx_24100005_lsu (DATA_W=32, TIMEOUT_CYC=8).
module tb_ysyx_24100005_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24100005_lsu #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full legal access: accept at cycle 0, mem_ready at 1, mem_rvalid at 2, response at 3.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                          input logic [31:0] exp_rdata);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid = 1'b0;
        check({tag, " mem_valid c1"}, 64'(mem_valid), 64'd1);
        check({tag, " mem_we"}, 64'(mem_we), 64'(we));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        check({tag, " mem_wmask"}, 64'(mem_wmask), 64'(exp_mask));
        check({tag, " resp_valid c1"}, 64'(resp_valid), 64'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        check({tag, " mem_valid c2"}, 64'(mem_valid), 64'd0);
        check({tag, " resp_valid c2"}, 64'(resp_valid), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check({tag, " resp_valid c3"}, 64'(resp_valid), 64'd1);
        check({tag, " resp_err"}, 64'(resp_err), 64'd0);
        check({tag, " resp_rdata"}, 64'(resp_rdata), 64'(exp_rdata));
        tick();
        check({tag, " resp_valid c4"}, 64'(resp_valid), 64'd0);
    endtask

    // Rejected request: error response at cycle 1, bus never requested.
    task automatic illegal(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        check({tag, " resp_valid c1"}, 64'(resp_valid), 64'd1);
        check({tag, " resp_err"}, 64'(resp_err), 64'd1);
        check({tag, " resp_rdata"}, 64'(resp_rdata), 64'd0);
        check({tag, " mem_valid c1"}, 64'(mem_valid), 64'd0);
        tick();
        check({tag, " resp_valid c2"}, 64'(resp_valid), 64'd0);
        check({tag, " mem_valid c2"}, 64'(mem_valid), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();

        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst resp_err", 64'(resp_err), 64'd0);
        check("rst mem_valid", 64'(mem_valid), 64'd0);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst mem_wmask", 64'(mem_wmask), 64'd0);
        rst = 1'b0;
        tick();

        //      tag    we    f3      addr          wdata         rdata         exp_addr      exp_wdata     mask     exp_rdata
        access("sw",   1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,        32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        access("lb",   1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        4'b1000, 32'hFFFF_FF80);
        access("lbu",  1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        4'b1000, 32'h0000_0080);
        access("sh",   1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0,        32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0);
        access("lh",   1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h8001_1234, 32'h8000_0000, 32'h0,        4'b1100, 32'hFFFF_8001);
        access("lhu",  1'b0, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 32'h8000_0000, 32'h0,        4'b0011, 32'h0000_F00D);
        access("sb",   1'b1, 3'b000, 32'h8000_0001, 32'h1122_33A5, 32'h0,        32'h8000_0000, 32'h2233_A500, 4'b0010, 32'h0);
        access("lw",   1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'h1234_5678, 32'h8000_0004, 32'h0,        4'b1111, 32'h1234_5678);

        illegal("ld32",  1'b0, 3'b011, 32'h8000_0000);
        illegal("lwu32", 1'b0, 3'b110, 32'h8000_0000);
        illegal("ld111", 1'b0, 3'b111, 32'h8000_0000);
        illegal("sd32",  1'b1, 3'b011, 32'h8000_0000);
        illegal("st100", 1'b1, 3'b100, 32'h8000_0000);

`ifdef YSYX_24100005_LSU_MISALIGN_CHK_EN
        illegal("mis lw",  1'b0, 3'b010, 32'h8000_0002);
        illegal("mis lhu", 1'b0, 3'b101, 32'h8000_0003);
`else
        access("mis lw",  1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 32'h8000_0000, 32'h0, 4'b1111, 32'hCAFE_F00D);
        access("mis lhu", 1'b0, 3'b101, 32'h8000_0003, 32'h0, 32'hBEEF_0000, 32'h8000_0000, 32'h0, 4'b1100, 32'h0000_BEEF);
`endif

        // Timeout: mem_ready never arrives, eight cycles in ADDR, error response at cycle 9.
        check("to req_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0008;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("to mem_valid held", 64'(mem_valid), 64'd1);
            check("to resp_valid early", 64'(resp_valid), 64'd0);
            tick();
        end
        check("to resp_valid", 64'(resp_valid), 64'd1);
        check("to resp_err", 64'(resp_err), 64'd1);
        check("to resp_rdata", 64'(resp_rdata), 64'd0);
        check("to mem_valid dropped", 64'(mem_valid), 64'd0);
        tick();
        check("to resp_valid after", 64'(resp_valid), 64'd0);
        check("to req_ready after", 64'(req_ready), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("late rvalid resp_valid", 64'(resp_valid), 64'd0);
        check("late rvalid req_ready", 64'(req_ready), 64'd1);
        check("late rvalid mem_valid", 64'(mem_valid), 64'd0);
        tick();
        check("late rvalid resp_valid 2", 64'(resp_valid), 64'd0);

        // Reset while in WAIT, with a bus response arriving in the same cycle.
        check("rw req_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0010;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        check("rw mem_valid c1", 64'(mem_valid), 64'd1);
        tick();
        mem_ready = 1'b0;
        check("rw mem_valid c2", 64'(mem_valid), 64'd0);
        check("rw req_ready c2", 64'(req_ready), 64'd0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("rw req_ready", 64'(req_ready), 64'd1);
        check("rw mem_valid", 64'(mem_valid), 64'd0);
        check("rw resp_valid", 64'(resp_valid), 64'd0);
        check("rw mem_addr", 64'(mem_addr), 64'd0);
        check("rw mem_wmask", 64'(mem_wmask), 64'd0);
        tick();
        check("rw resp_valid 2", 64'(resp_valid), 64'd0);
        access("lw post rst", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0BAD_F00D, 32'h8000_0010, 32'h0, 4'b1111, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
